// File: rtl/alu_reservation_station.sv
// Integer reservation station: holds dispatched ALU ops until both operands resolve,
// snoops the CDB, and issues the oldest-by-index ready entry with its computed result.
module alu_reservation_station #(
  parameter int RS_SIZE = 8,
  parameter int ROB_W   = 5
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             _clear,
  input  logic             _issue_valid,
  input  logic [3:0]       _issue_op,
  input  logic [ROB_W-1:0] _issue_rob_id,
  input  logic [31:0]      _issue_vj,
  input  logic [31:0]      _issue_vk,
  input  logic             _issue_qj_valid,
  input  logic             _issue_qk_valid,
  input  logic [ROB_W-1:0] _issue_qj,
  input  logic [ROB_W-1:0] _issue_qk,
  output logic             _rs_full,
  input  logic             _cdb_ready,
  input  logic [ROB_W-1:0] _cdb_rob_id,
  input  logic [31:0]      _cdb_value,
  input  logic             _alu_full,
  output logic             _alu_ready,
  output logic [ROB_W-1:0] _alu_rob_id,
  output logic [31:0]      _alu_value
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [RS_SIZE-1:0] valid_q, valid_d;
  logic [RS_SIZE-1:0] pj_q, pj_d, pk_q, pk_d;
  logic [3:0]         op_q [RS_SIZE];
  logic [3:0]         op_d [RS_SIZE];
  logic [ROB_W-1:0]   rob_q [RS_SIZE];
  logic [ROB_W-1:0]   rob_d [RS_SIZE];
  logic [ROB_W-1:0]   qj_q [RS_SIZE];
  logic [ROB_W-1:0]   qj_d [RS_SIZE];
  logic [ROB_W-1:0]   qk_q [RS_SIZE];
  logic [ROB_W-1:0]   qk_d [RS_SIZE];
  logic [31:0]        vj_q [RS_SIZE];
  logic [31:0]        vj_d [RS_SIZE];
  logic [31:0]        vk_q [RS_SIZE];
  logic [31:0]        vk_d [RS_SIZE];

  logic             alu_ready_q, alu_ready_d;
  logic [ROB_W-1:0] alu_rob_id_q, alu_rob_id_d;
  logic [31:0]      alu_value_q, alu_value_d;

  logic [RS_SIZE-1:0] ready_vec, hit_j, hit_k;
  logic [IDX_W-1:0]   free_idx, cand_idx;
  logic               cand_found;
  logic               fwd_j, fwd_k;
  logic [31:0]        cand_result;

  function automatic logic [31:0] alu_calc(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = a << b[4:0];
      4'd6:    r = a >> b[4:0];
      4'd7:    r = $unsigned($signed(a) >>> b[4:0]);
      4'd8:    r = {31'd0, $signed(a) < $signed(b)};
      4'd9:    r = {31'd0, a < b};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Readiness and CDB matches are judged on start-of-cycle state only.
  genvar gi;
  generate
    for (gi = 0; gi < RS_SIZE; gi++) begin : g_entry
      assign ready_vec[gi] = valid_q[gi] & ~pj_q[gi] & ~pk_q[gi];
      assign hit_j[gi] = _cdb_ready & valid_q[gi] & pj_q[gi] & (qj_q[gi] == _cdb_rob_id);
      assign hit_k[gi] = _cdb_ready & valid_q[gi] & pk_q[gi] & (qk_q[gi] == _cdb_rob_id);
    end
  endgenerate

  assign _rs_full = &valid_q;
  assign fwd_j = _issue_qj_valid & _cdb_ready & (_issue_qj == _cdb_rob_id);
  assign fwd_k = _issue_qk_valid & _cdb_ready & (_issue_qk == _cdb_rob_id);

  always_comb begin
    free_idx   = '0;
    cand_idx   = '0;
    cand_found = 1'b0;
    // Descending scan leaves the lowest matching index selected.
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
      if (ready_vec[i]) begin
        cand_idx   = IDX_W'(i);
        cand_found = 1'b1;
      end
    end
  end

  assign cand_result = alu_calc(op_q[cand_idx], vj_q[cand_idx], vk_q[cand_idx]);

  always_comb begin
    valid_d      = valid_q;
    pj_d         = pj_q;
    pk_d         = pk_q;
    op_d         = op_q;
    rob_d        = rob_q;
    qj_d         = qj_q;
    qk_d         = qk_q;
    vj_d         = vj_q;
    vk_d         = vk_q;
    alu_ready_d  = 1'b0;
    alu_rob_id_d = alu_rob_id_q;
    alu_value_d  = alu_value_q;
    if (rdy_in) begin
      if (_clear) begin
        valid_d = '0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (hit_j[i]) begin
            vj_d[i] = _cdb_value;
            pj_d[i] = 1'b0;
          end
          if (hit_k[i]) begin
            vk_d[i] = _cdb_value;
            pk_d[i] = 1'b0;
          end
        end
        if (cand_found && !_alu_full) begin
          alu_ready_d        = 1'b1;
          alu_rob_id_d       = rob_q[cand_idx];
          alu_value_d        = cand_result;
          valid_d[cand_idx]  = 1'b0;
        end
        // A full station refuses dispatch even if an entry leaves this cycle.
        if (_issue_valid && !_rs_full) begin
          valid_d[free_idx] = 1'b1;
          op_d[free_idx]    = _issue_op;
          rob_d[free_idx]   = _issue_rob_id;
          qj_d[free_idx]    = _issue_qj;
          qk_d[free_idx]    = _issue_qk;
          vj_d[free_idx]    = fwd_j ? _cdb_value : _issue_vj;
          vk_d[free_idx]    = fwd_k ? _cdb_value : _issue_vk;
          pj_d[free_idx]    = _issue_qj_valid & ~fwd_j;
          pk_d[free_idx]    = _issue_qk_valid & ~fwd_k;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_q      <= '0;
      pj_q         <= '0;
      pk_q         <= '0;
      alu_ready_q  <= 1'b0;
      alu_rob_id_q <= '0;
      alu_value_q  <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op_q[i]  <= '0;
        rob_q[i] <= '0;
        qj_q[i]  <= '0;
        qk_q[i]  <= '0;
        vj_q[i]  <= '0;
        vk_q[i]  <= '0;
      end
    end else begin
      valid_q      <= valid_d;
      pj_q         <= pj_d;
      pk_q         <= pk_d;
      op_q         <= op_d;
      rob_q        <= rob_d;
      qj_q         <= qj_d;
      qk_q         <= qk_d;
      vj_q         <= vj_d;
      vk_q         <= vk_d;
      alu_ready_q  <= alu_ready_d;
      alu_rob_id_q <= alu_rob_id_d;
      alu_value_q  <= alu_value_d;
    end
  end

  assign _alu_ready  = alu_ready_q;
  assign _alu_rob_id = alu_rob_id_q;
  assign _alu_value  = alu_value_q;

endmodule
